// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the flexible-depth FIFO.
package fifo_pkg;

    // Smallest depth for which full and empty can be told apart.
    localparam int FIFO_MIN_DEPTH = 2;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Pointer that counts 0..DEPTH-1 and wraps explicitly, so DEPTH need
// not be a power of two.
module fifo_wrap_ptr #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    // Next pointer: flush wins, otherwise advance with compare-and-reset wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            if (ptr_q == WIDTH'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_flex.sv
// Synchronous first-word-fall-through FIFO with arbitrary depth, occupancy
// count, programmable almost-full/almost-empty and sticky error flags.
module fifo_flex
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH  = 16,
    parameter  int FIFO_DEPTH  = 4,
    localparam int COUNT_WIDTH = clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   enq,
    output logic                   full_n,
    output logic [DATA_WIDTH-1:0]  dout,
    input  logic                   deq,
    output logic                   empty_n,
    input  logic                   clr,
    input  logic [COUNT_WIDTH-1:0] af_thresh,
    input  logic [COUNT_WIDTH-1:0] ae_thresh,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PTR_WIDTH = (clog2(FIFO_DEPTH) < 1) ? 1 : clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < FIFO_MIN_DEPTH) begin : g_depth_check
        $error("fifo_flex: FIFO_DEPTH must be at least %0d", FIFO_MIN_DEPTH);
    end

    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   overflow_q;
    logic                   overflow_d;
    logic                   underflow_q;
    logic                   underflow_d;
    logic                   enq_ok;
    logic                   deq_ok;

    // Status decoded from the registered occupancy only.
    assign empty_n      = (count_q != '0);
    assign full_n       = (count_q != COUNT_WIDTH'(FIFO_DEPTH));
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A pop from a full FIFO frees the slot the simultaneous push uses.
    // Flush suppresses both so no stray write or flag survives it.
    assign deq_ok = deq & empty_n & ~clr;
    assign enq_ok = enq & (full_n | deq) & ~clr;

    // Head of queue, forced to zero when empty so stale or unwritten
    // storage never reaches the output.
    assign dout = empty_n ? mem_q[rd_ptr] : '0;

    fifo_wrap_ptr #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PTR_WIDTH)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (enq_ok),
        .ptr   (wr_ptr)
    );

    fifo_wrap_ptr #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PTR_WIDTH)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (deq_ok),
        .ptr   (rd_ptr)
    );

    // Next occupancy and sticky error flags.
    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            unique case ({enq_ok, deq_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (enq && !full_n && !deq) begin
                overflow_d = 1'b1;
            end
            if (deq && !empty_n) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Occupancy and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (enq_ok) begin
            mem_q[wr_ptr] <= din;
        end
    end

endmodule

// File: tb/tb_fifo_flex.sv
// Directed plus randomized bench for fifo_flex, checked against a queue model.
module tb_fifo_flex;

    localparam int DW    = 16;
    localparam int DEPTH = 5;
    localparam int CW    = 3;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          enq;
    logic          full_n;
    logic [DW-1:0] dout;
    logic          deq;
    logic          empty_n;
    logic          clr;
    logic [CW-1:0] af_thresh;
    logic [CW-1:0] ae_thresh;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    fifo_flex #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .enq          (enq),
        .full_n       (full_n),
        .dout         (dout),
        .deq          (deq),
        .empty_n      (empty_n),
        .clr          (clr),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents as a queue, plus the two sticky flags.
    logic [DW-1:0] model_q[$];
    logic          m_ovf;
    logic          m_unf;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        logic [DW-1:0] head;
        sz   = model_q.size();
        head = (sz != 0) ? model_q[0] : '0;
        chk({tag, ".count"},   32'(count),        32'(sz));
        chk({tag, ".empty_n"}, 32'(empty_n),      32'(sz != 0));
        chk({tag, ".full_n"},  32'(full_n),       32'(sz != DEPTH));
        chk({tag, ".dout"},    32'(dout),         32'(head));
        chk({tag, ".af"},      32'(almost_full),  32'(sz >= int'(af_thresh)));
        chk({tag, ".ae"},      32'(almost_empty), 32'(sz <= int'(ae_thresh)));
        chk({tag, ".ovf"},     32'(overflow),     32'(m_ovf));
        chk({tag, ".unf"},     32'(underflow),    32'(m_unf));
    endtask

    // Apply the queue rules for one clock edge.
    task automatic model_edge(input logic e, input logic [DW-1:0] d, input logic dq, input logic c);
        int sz;
        bit popped;
        sz = model_q.size();
        popped = 0;
        if (c) begin
            model_q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (dq) begin
                if (sz > 0) begin
                    void'(model_q.pop_front());
                    popped = 1;
                end else begin
                    m_unf = 1;
                end
            end
            if (e) begin
                if (sz < DEPTH || popped) model_q.push_back(d);
                else m_ovf = 1;
            end
        end
    endtask

    task automatic cycle(input string tag, input logic e, input logic [DW-1:0] d,
                         input logic dq, input logic c);
        enq = e; din = d; deq = dq; clr = c;
        @(posedge clk);
        model_edge(e, d, dq, c);
        #1;
        $display("%s: enq=%0b din=%h deq=%0b clr=%0b -> count=%0d dout=%h ovf=%0b unf=%0b",
                 tag, e, d, dq, c, count, dout, overflow, underflow);
        check_all(tag);
        enq = 0; deq = 0; clr = 0;
    endtask

    initial begin
        logic [DW-1:0] vals [5];
        vals[0] = 16'h11; vals[1] = 16'h22; vals[2] = 16'h33; vals[3] = 16'h44; vals[4] = 16'h55;
        rst_n = 0; enq = 0; deq = 0; clr = 0; din = '0;
        af_thresh = 3'd4; ae_thresh = 3'd1;
        m_ovf = 0; m_unf = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1;

        // Fill in order, then drain; full_n must drop only at count 5.
        for (int i = 0; i < 5; i++) cycle("fill", 1, vals[i], 0, 0);
        chk("full_at_5", 32'(full_n), 32'(0));
        for (int i = 0; i < 5; i++) begin
            chk("drain_head", 32'(dout), 32'(vals[i]));
            cycle("drain", 0, '0, 1, 0);
        end
        chk("empty_end", 32'(empty_n), 32'(0));

        // Overflow on a full FIFO, then flush.
        for (int i = 0; i < 5; i++) cycle("fill2", 1, vals[i], 0, 0);
        cycle("ovf", 1, 16'h66, 0, 0);
        chk("ovf_set", 32'(overflow), 32'(1));
        cycle("clr", 1, 16'h77, 1, 1);
        chk("clr_count", 32'(count), 32'(0));

        // Full with simultaneous push/pop: pointers wrap, order kept.
        for (int i = 0; i < 5; i++) cycle("fill3", 1, vals[i], 0, 0);
        for (int i = 0; i < 7; i++) cycle("pushpop", 1, 16'(16'h100 + i), 1, 0);
        for (int i = 0; i < 5; i++) cycle("drain3", 0, '0, 1, 0);

        // Push/pop on empty: underflow, but the push lands.
        cycle("unf", 1, 16'hAB, 1, 0);
        chk("unf_dout", 32'(dout), 32'(16'hAB));
        cycle("clr2", 0, '0, 0, 1);

        // Threshold corners take effect combinationally.
        af_thresh = 3'd0; ae_thresh = 3'd5;
        #1;
        check_all("thr_corner");
        af_thresh = 3'd4; ae_thresh = 3'd1;
        #1;
        check_all("thr_nominal");

        // Randomized traffic with occasional flush and threshold changes.
        for (int i = 0; i < 400; i++) begin
            if ((i % 37) == 0) begin
                af_thresh = CW'($urandom_range(0, 7));
                ae_thresh = CW'($urandom_range(0, 7));
            end
            cycle("rand", 1'($urandom_range(0, 1)), 16'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
        end

        // Asynchronous reset with data held.
        cycle("pre_rst_clr", 0, '0, 0, 1);
        af_thresh = 3'd4; ae_thresh = 3'd1;
        for (int i = 0; i < 3; i++) cycle("pre_rst", 1, vals[i], 0, 0);
        #2;
        rst_n = 0;
        model_q.delete();
        m_ovf = 0; m_unf = 0;
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1;
        cycle("post_rst", 1, 16'h7, 0, 0);
        chk("post_rst_dout", 32'(dout), 32'(16'h7));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
- Next-generation synchronous FIFO for streaming datapaths (audio front-end to feature extraction and NN stages); keeps the din/enq/full_n/dout/deq/empty_n/clr handshake.
- Adds arbitrary non-power-of-two depth, an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Storage is an internal register array; output is first-word-fall-through.

Parameters:
- DATA_WIDTH, 16, payload width in bits (>=1).
- FIFO_DEPTH, 4, number of entries (>=2, any integer, not restricted to powers of two).
- COUNT_WIDTH, localparam = $clog2(FIFO_DEPTH+1), width of count and thresholds (derived, not overridable).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  DATA_WIDTH  write data.
- enq  input  1  write request.
- full_n  output  1  1 = space available.
- dout  output  DATA_WIDTH  head-of-queue data, valid when empty_n=1.
- deq  input  1  read/pop request.
- empty_n  output  1  1 = data available.
- clr  input  1  synchronous flush.
- af_thresh  input  COUNT_WIDTH  almost-full threshold.
- ae_thresh  input  COUNT_WIDTH  almost-empty threshold.
- count  output  COUNT_WIDTH  current occupancy, 0..FIFO_DEPTH.
- almost_full  output  1  count >= af_thresh.
- almost_empty  output  1  count <= ae_thresh.
- overflow  output  1  sticky: an enq was dropped.
- underflow  output  1  sticky: a deq hit an empty FIFO.

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=rd_ptr=0, count=0, empty_n=0, full_n=1, overflow=0, underflow=0, dout=0. Storage array is not reset.
- Outputs are decoded from registered count:
  - empty_n = (count!=0); full_n = (count!=FIFO_DEPTH).
  - almost_full and almost_empty are combinational compares on count.
- dout = mem[rd_ptr] when empty_n=1, else 0 (no X leakage).
- Accepted enq (enq & (full_n | deq)): writes din at wr_ptr on the edge. Data is visible on dout and empty_n=1 in the following cycle (latency 1, no same-cycle bypass).
- Accepted deq (deq & empty_n): advances rd_ptr on the edge; the next entry appears on dout the following cycle.
- Simultaneous enq+deq:
  - Non-empty, non-full: both accepted, count unchanged.
  - Full: both accepted (the pop frees the slot), count unchanged, no overflow.
  - Empty: deq is an underflow, enq accepted, count becomes 1.
- Dropped enq (enq & ~full_n & ~deq): data discarded, overflow set to 1 and held.
- deq when empty_n=0: no state change except underflow set to 1 and held.
- Pointers wrap FIFO_DEPTH-1 -> 0 explicitly (compare-and-reset, not a modulo 2^n counter).
- clr=1 (synchronous, highest priority over enq/deq):
  - Next cycle: pointers=0, count=0, empty_n=0, full_n=1, overflow=0, underflow=0.
  - enq/deq in the same cycle are ignored and set no flags.
- Reset asserted mid-operation: all state returns to reset values immediately. First post-reset enq behaves as on an empty FIFO.
- Threshold corner cases: af_thresh=0 forces almost_full=1; ae_thresh>=FIFO_DEPTH forces almost_empty=1. Thresholds may change any cycle and take effect combinationally.

Decomposition:
- Shared package fifo_pkg holds:
  - a clog2 function for COUNT_WIDTH derivation;
  - a FIFO_MIN_DEPTH=2 constant checked by an elaboration-time assertion.
- One sub-module, fifo_wrap_ptr (parameters DEPTH, WIDTH; inputs clk, rst_n, clr, inc; output ptr): a wrapping pointer, instantiated for wr_ptr and rd_ptr.
- Array, count, flags and output decode live in fifo_flex.

Test Plan:
- DEPTH=5: enq 0x11,0x22,0x33,0x44,0x55 on consecutive cycles, then 5 deqs -> dout sequence 0x11..0x55; full_n=0 exactly while count=5; empty_n=0 at the end.
- DEPTH=5, full: assert enq 0x66 without deq -> overflow=1, count stays 5, 0x66 never appears. Then clr -> count=0, overflow=0, empty_n=0 next cycle.
- DEPTH=5, full: enq+deq for 7 cycles -> count stays 5, no overflow, pointers wrap, output order preserved.
- Empty FIFO: deq+enq 0xAB same cycle -> underflow=1, count=1, dout=0xAB next cycle.
- af_thresh=4, ae_thresh=1: fill to 5 and drain -> almost_full=1 at count 4..5, almost_empty=1 at count 0..1.
- Reset: assert rst_n=0 asynchronously with count=3 -> outputs at reset values immediately. Release, enq 0x7 -> dout=0x7 one cycle later.
